// File: rtl/log2_shared_scheduler.sv
// Shares one pipelined log2 core among NUM_REQ requesters.
// Round-robin issue, one outstanding op per requester, tag pipeline routes results back.
module log2_shared_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned LOG_LATENCY = 2,
    parameter int unsigned DIN_W       = 24,
    parameter int unsigned DOUT_W      = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DIN_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DIN_W-1:0]           log_din,
    input  logic [DOUT_W-1:0]          log_dout,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DOUT_W-1:0]          rsp_data,
    output logic                       busy
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned STAGES = LOG_LATENCY + 1;

    logic [NUM_REQ-1:0] r_pending;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [DIN_W-1:0]   r_log_din;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DOUT_W-1:0]  r_rsp_data;
    logic               r_busy;
    logic [STAGES-1:0]  r_tag_vld;
    logic [IDX_W-1:0]   r_tag_idx [STAGES];

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [IDX_W-1:0]   w_cand;
    logic               w_found;
    logic               w_accept;
    logic [DIN_W-1:0]   w_sel_data;
    logic               w_rsp_hit;
    logic [NUM_REQ-1:0] w_rsp_onehot;
    logic [NUM_REQ-1:0] w_pending_nxt;

    assign w_eligible = req_valid & ~r_pending;

    // First eligible requester at or after the round-robin pointer
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_cand      = '0;
        w_found     = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && w_eligible[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
        if (w_found) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_data = req_data[i*DIN_W +: DIN_W];
            end
        end
    end

    assign w_accept      = w_found;
    assign w_rsp_hit     = r_tag_vld[LOG_LATENCY];
    assign w_rsp_onehot  = w_rsp_hit ? (NUM_REQ'(1) << r_tag_idx[LOG_LATENCY]) : '0;
    assign w_pending_nxt = (r_pending | w_grant) & ~w_rsp_onehot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending   <= '0;
            r_rr_ptr    <= '0;
            r_log_din   <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
            r_tag_vld   <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                r_tag_idx[s] <= '0;
            end
        end else begin
            r_pending   <= w_pending_nxt;
            r_busy      <= |w_pending_nxt;
            r_rsp_valid <= w_rsp_onehot;
            if (w_rsp_hit) begin
                r_rsp_data <= log_dout;
            end
            if (w_accept) begin
                r_rr_ptr  <= IDX_W'((32'(w_grant_idx) + 32'd1) % NUM_REQ);
                r_log_din <= w_sel_data;
            end
            // Tag shadows the core pipeline so stage LOG_LATENCY lines up with log_dout
            r_tag_vld[0] <= w_accept;
            r_tag_idx[0] <= w_grant_idx;
            for (int unsigned s = 1; s < STAGES; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end
        end
    end

    assign req_ready = w_grant & {NUM_REQ{~reset}};
    assign log_din   = r_log_din;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_log2_shared_scheduler.sv
// Bench for log2_shared_scheduler: log2 core model, scoreboard of issued operations,
// a table of single-request vectors and directed multi-cycle sequences.
module tb_log2_shared_scheduler;

    localparam int NR = 4;
    localparam int DW = 24;
    localparam int OW = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [DW-1:0]   log_din;
    logic [OW-1:0]   log_dout;
    logic [NR-1:0]   rsp_valid;
    logic [OW-1:0]   rsp_data;
    logic            busy;

    log2_shared_scheduler #(.NUM_REQ(NR), .LOG_LATENCY(2), .DIN_W(DW), .DOUT_W(OW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .log_din(log_din), .log_dout(log_dout),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference log2: integer part from msb position, fraction from the next 8 bits
    function automatic logic [OW-1:0] ref_log2(input logic [DW-1:0] x);
        int p;
        logic [DW-1:0] m;
        logic [7:0] fr;
        if (x == '0) return '0;
        p = 0;
        for (int b = 0; b < DW; b++) if (x[b]) p = b;
        m  = x << (DW - 1 - p);
        fr = m[DW-2 -: 8];
        return OW'(((p - 8) * 256) + int'(fr));
    endfunction

    // Core model with two-edge latency
    logic [OW-1:0] core_s1;
    always @(posedge clk) begin
        core_s1  <= ref_log2(log_din);
        log_dout <= core_s1;
    end

    typedef struct { int idx; logic [DW-1:0] data; logic [OW-1:0] exp; } vec_t;
    typedef struct { int idx; logic [OW-1:0] exp; int issue; } sb_t;

    sb_t   sb[$];
    int    g_idx[$], g_cyc[$], r_idx[$], r_cyc[$];
    logic [OW-1:0] r_dat[$];
    logic [NR-1:0] tb_pend;
    logic [NR-1:0] last_acc;
    int    cyc;
    int    n_vec, n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        g_idx.delete(); g_cyc.delete(); r_idx.delete(); r_cyc.delete(); r_dat.delete();
    endtask

    // One clock: record accepts before the edge, score responses after it
    task automatic tick();
        logic [NR-1:0] acc;
        int gi;
        sb_t e;
        @(negedge clk);
        acc = req_valid & req_ready;
        last_acc = acc;
        if (acc != '0) begin
            chk("grant_onehot", $countones(acc), 1);
            gi = 0;
            for (int i = 0; i < NR; i++) if (acc[i]) gi = i;
            chk("grant_not_pending", 32'(tb_pend[gi]), 0);
            sb.push_back('{gi, ref_log2(req_data[gi*DW +: DW]), cyc + 1});
            tb_pend[gi] = 1'b1;
            g_idx.push_back(gi);
            g_cyc.push_back(cyc + 1);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_route", 32'(rsp_valid), 32'd1 << e.idx);
                chk("rsp_data", 32'(rsp_data), 32'(e.exp));
                chk("rsp_latency", cyc - e.issue, 3);
                tb_pend[e.idx] = 1'b0;
                r_idx.push_back(e.idx);
                r_dat.push_back(rsp_data);
                r_cyc.push_back(cyc);
            end
        end
        chk("busy", 32'(busy), 32'(|tb_pend));
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 20), 1);
    endtask

    task automatic do_single(input int idx, input logic [DW-1:0] data, input logic [OW-1:0] exp);
        int n;
        req_data[idx*DW +: DW] = data;
        req_valid = NR'(1) << idx;
        #1;
        chk("single_ready", 32'(req_ready), 32'd1 << idx);
        tick();
        chk("single_accept", 32'(last_acc), 32'd1 << idx);
        req_valid = '0;
        n = 0;
        do begin
            tick();
            n++;
            if (rsp_valid == '0) chk("single_busy", 32'(busy), 1);
        end while (rsp_valid == '0 && n < 8);
        chk("single_latency", n, 3);
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1 << idx);
        chk("single_rsp_data", 32'(rsp_data), 32'(exp));
        tick();
        chk("single_pulse_end", 32'(rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [OW-1:0] rr_exp[4];
        int fair_exp[6];
        logic [DW-1:0] held_din;
        int n;

        tbl[0] = '{0, 24'h001000, 12'h400};
        tbl[1] = '{2, 24'h000300, 12'h180};
        tbl[2] = '{1, 24'h000100, 12'h000};
        tbl[3] = '{0, 24'h000080, 12'hF00};
        tbl[4] = '{2, 24'h000200, 12'h100};
        tbl[5] = '{3, 24'h000400, 12'h200};
        rr_exp   = '{12'h000, 12'h100, 12'h200, 12'h400};
        fair_exp = '{3, 1, 3, 1, 3, 1};

        n_vec = 0; n_err = 0; cyc = 0;
        tb_pend = '0; last_acc = '0;
        reset = 1'b1;
        req_valid = '1;
        req_data = {24'h001000, 24'h000400, 24'h000200, 24'h000100};

        // Reset state, with requests present to show grants are held off
        repeat (2) tick();
        chk("rst_log_din", 32'(log_din), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        reset = 1'b0;
        req_valid = '0;
        tick();

        for (int v = 0; v < 6; v++) do_single(tbl[v].idx, tbl[v].data, tbl[v].exp);

        // Round-robin: all four at once, pointer at 0
        clear_logs();
        req_data = {24'h001000, 24'h000400, 24'h000200, 24'h000100};
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            req_valid = req_valid & ~last_acc;
        end
        req_valid = '0;
        chk("rr_grant_count", g_idx.size(), 4);
        for (int k = 0; k < 4 && k < g_idx.size(); k++) begin
            chk("rr_grant_order", g_idx[k], k);
            chk("rr_grant_cycle", g_cyc[k] - g_cyc[0], k);
        end
        n = 0;
        while (r_idx.size() < 4 && n < 10) begin tick(); n++; end
        chk("rr_rsp_count", r_idx.size(), 4);
        for (int k = 0; k < 4 && k < r_idx.size(); k++) begin
            chk("rr_rsp_index", r_idx[k], k);
            chk("rr_rsp_data", 32'(r_dat[k]), 32'(rr_exp[k]));
            chk("rr_rsp_cycle", r_cyc[k] - r_cyc[0], k);
        end
        drain();

        // Fairness: move pointer to 2, then 1 and 3 request continuously
        do_single(1, 24'h000400, 12'h200);
        clear_logs();
        req_data[1*DW +: DW] = 24'h000800;
        req_data[3*DW +: DW] = 24'h002000;
        req_valid = 4'b1010;
        n = 0;
        while (g_idx.size() < 6 && n < 40) begin tick(); n++; end
        req_valid = '0;
        chk("fair_grant_count", g_idx.size(), 6);
        for (int k = 0; k < 6 && k < g_idx.size(); k++) begin
            chk("fair_grant_order", g_idx[k], fair_exp[k]);
            if (k == 1) chk("fair_back_to_back", g_cyc[1] - g_cyc[0], 1);
            if (k >= 2) chk("fair_period", g_cyc[k] - g_cyc[k-2], 4);
        end
        drain();

        // One outstanding: requester 2 holds req_valid
        clear_logs();
        req_data[2*DW +: DW] = 24'h000100;
        req_valid = 4'b0100;
        last_acc = '0;
        n = 0;
        while (last_acc[2] == 1'b0 && n < 10) begin tick(); n++; end
        chk("oo_first_accept", 32'(last_acc), 32'h4);
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 3; k++) begin
                chk("oo_ready_low", 32'(req_ready), 0);
                tick();
            end
            chk("oo_regrant_ready", 32'(req_ready), 32'h4);
            chk("oo_rsp_pulse", 32'(rsp_valid), 32'h4);
            tick();
            chk("oo_reaccept", 32'(last_acc), 32'h4);
        end
        req_valid = '0;
        for (int k = 1; k < g_cyc.size(); k++) chk("oo_period", g_cyc[k] - g_cyc[k-1], 4);
        drain();

        // Reset one cycle after an accept discards the operation
        req_data[0 +: DW] = 24'h001000;
        req_valid = 4'b0001;
        tick();
        chk("rmf_accept", 32'(last_acc), 32'h1);
        req_valid = '0;
        tick();
        reset = 1'b1;
        sb.delete();
        tb_pend = '0;
        req_valid = 4'b0001;
        #1;
        chk("rmf_log_din", 32'(log_din), 0);
        chk("rmf_rsp_valid", 32'(rsp_valid), 0);
        chk("rmf_rsp_data", 32'(rsp_data), 0);
        chk("rmf_busy", 32'(busy), 0);
        chk("rmf_req_ready", 32'(req_ready), 0);
        repeat (3) begin tick(); chk("rmf_no_rsp_in_reset", 32'(rsp_valid), 0); end
        reset = 1'b0;
        req_valid = '0;
        repeat (4) begin tick(); chk("rmf_no_rsp_after", 32'(rsp_valid), 0); end
        do_single(1, 24'h000200, 12'h100);

        // Idle: everything holds; pointer still 2 after the last grant to 1
        held_din = log_din;
        chk("idle_din_start", 32'(held_din), 32'h200);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_din", 32'(log_din), 32'(held_din));
            chk("idle_rsp", 32'(rsp_valid), 0);
            chk("idle_busy", 32'(busy), 0);
        end
        req_data = {24'h000100, 24'h000200, 24'h000400, 24'h000800};
        req_valid = 4'hF;
        tick();
        chk("idle_rr_ptr", 32'(last_acc), 32'h4);
        req_valid = req_valid & ~last_acc;
        n = 0;
        while (req_valid != '0 && n < 10) begin
            tick();
            req_valid = req_valid & ~last_acc;
            n++;
        end
        req_valid = '0;
        chk("idle_all_granted", 32'(n < 10), 1);
        drain();

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
